fp_trig_special_stage: RTL and testbench
========================================

// Module: fp_trig_special_stage
// PURPOSE
//  Parametrised, pipelined final-result stage for the SINE/COSINE datapath.
//  - Classifies the original operand as zero, subnormal, Inf, qNaN or sNaN.
//  - Replaces the core's raw result with the IEEE-754 result for sin/cos special cases.
//  - Raises per-result exception flags and keeps a sticky invalid bit.
//  - Sits between the trig core output and the bus; valid/ready on both sides.
// PARAMETERS
//  EXP_W      8  exponent width (5 = half, 8 = single, 11 = double)
//  MAN_W      23 fraction width (10 / 23 / 52); W = 1+EXP_W+MAN_W
//  CANON_NAN  0  1: every NaN out is canonical qNaN; 0: quieted input NaN is propagated
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    synchronous reset, active-high
//  in_valid      in   1    operand/core pair valid
//  in_ready      out  1    stage can accept this cycle
//  in_op         in   W    original operand x
//  in_core       in   W    core result for x (sin or cos)
//  in_func       in   1    0 = sin, 1 = cos
//  out_valid     out  1    result valid
//  out_ready     in   1    downstream accepts
//  out_result    out  W    final result
//  out_flags     out  3    {invalid, inexact, special}, aligned with out_result
//  sticky_inv    out  1    OR of all delivered invalid flags since reset/clear
//  clr_sticky    in   1    clears sticky_inv
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//  - All valid bits, out_result, out_flags and sticky_inv go to 0.
//  - in_ready is 1 in the first cycle after reset.
//  - A transaction in flight when reset is taken is dropped.
//  Pipeline: two register stages, S1 (classify) and S2 (select/output).
//  - Advance enable: en = !out_valid | out_ready. in_ready = en.
//  - Transfer occurs when in_valid & in_ready. The result appears on out_* 2 cycles later.
//  - Full throughput of 1 per cycle when out_ready is held high.
//  - Stall: when en = 0, both stages hold. out_result and out_flags stay stable while out_valid & !out_ready.
//  - Bubbles are carried through the pipeline, not collapsed.
//  Classification (S1), with E = exponent and F = fraction of in_op:
//  - zero  : E = 0, F = 0
//  - sub   : E = 0, F != 0
//  - inf   : E = all ones, F = 0
//  - qnan  : E = all ones, F[MAN_W-1] = 1
//  - snan  : E = all ones, F != 0, F[MAN_W-1] = 0
//  - Only one class is active at a time. A normal operand activates none.
//  Selection (S2):
//  - Precedence is NaN > inf > zero > sub > normal.
//  - ONE = {1'b0, (2^(EXP_W-1))-1, MAN_W'b0}
//  - QNAN = {1'b0, all-ones, 1'b1, (MAN_W-1)'b0}
//  - Results and flags per case:
//      NaN      -> QNAN if CANON_NAN, else in_op with F[MAN_W-1] forced to 1 (sign and payload kept);
//                  invalid = snan; special = 1
//      inf      -> QNAN; invalid = 1; special = 1 (sign of input ignored)
//      zero     -> sin: in_op (signed zero kept); cos: ONE; special = 1
//      sub      -> sin: in_op; cos: ONE; inexact = 1; special = 1
//      normal   -> in_core passed unmodified; flags = 0
//  Sticky flag:
//  - sticky_inv is set when a result with invalid = 1 is accepted (out_valid & out_ready).
//  - clr_sticky clears it.
//  - If a set and a clear occur in the same cycle, the set wins.
//  No arithmetic is performed; in_core is never inspected for the special-case classes.
// TESTING
//  1. Single precision, sin, in_op = 32'h3F000000 (normal), in_core = 32'h3EF57744
//     -> 2 cycles later out_result = 32'h3EF57744, out_flags = 3'b000.
//  2. Signed zero: sin(32'h80000000) -> 32'h80000000, flags 3'b001;
//     cos(32'h80000000) -> 32'h3F800000, flags 3'b001.
//  3. sin(32'hFF800000) -> 32'h7FC00000, flags 3'b101, sticky_inv = 1 after the handshake.
//     clr_sticky in the same cycle as a further invalid handshake -> sticky_inv stays 1.
//  4. sNaN 32'h7F800001:
//     - CANON_NAN = 0 -> 32'h7FC00001, flags 3'b101
//     - CANON_NAN = 1 -> 32'h7FC00000, flags 3'b101
//     qNaN 32'hFFC00123 with CANON_NAN = 0 -> 32'hFFC00123, flags 3'b001.
//  5. Back-to-back 8 operands with out_ready toggled randomly:
//     - no loss or duplication, order preserved
//     - out_result stable during stall
//     - rst asserted mid-stream -> out_valid = 0 next cycle
//  6. EXP_W = 5, MAN_W = 10: cos(16'h0001) -> 16'h3C00, flags 3'b011;
//     sin(16'h7C00) -> 16'h7E00, flags 3'b101.

Source files
------------

// File: rtl/fp_trig_special_stage_if.sv
// Operand/core-result input side and final-result output side of the sin/cos
// special-case stage, together with the sticky-invalid status and its clear.
interface fp_trig_special_stage_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_op;
  logic [W-1:0] in_core;
  logic         in_func;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [2:0]   out_flags;
  logic         sticky_inv;
  logic         clr_sticky;

  modport master (
    output in_valid, in_op, in_core, in_func, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_flags, sticky_inv
  );

  modport slave (
    input  in_valid, in_op, in_core, in_func, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_flags, sticky_inv
  );
endinterface

// File: rtl/fp_trig_special_stage.sv
// Two-stage final-result stage for sin/cos: classifies the original operand,
// substitutes IEEE-754 special-case results and raises exception flags.
module fp_trig_special_stage #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter bit CANON_NAN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_trig_special_stage_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [W-1:0] ONE   = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] QUIET = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic               en;
  logic [EXP_W-1:0]   exp_in;
  logic [MAN_W-1:0]   frac_in;
  logic               exp_zero, exp_ones, frac_zero, frac_msb;

  logic               v1_reg;
  logic [W-1:0]       op1_reg;
  logic [W-1:0]       core1_reg;
  logic               func1_reg;
  logic               zero1_reg, sub1_reg, inf1_reg, qnan1_reg, snan1_reg;

  logic               out_valid_reg;
  logic [W-1:0]       out_result_reg;
  logic [2:0]         out_flags_reg;
  logic               sticky_reg;

  logic [W-1:0]       sel_result;
  logic [2:0]         sel_flags;

  // Both stages advance together, so bubbles move through rather than collapse.
  assign en           = !out_valid_reg | bus.out_ready;
  assign bus.in_ready = en;

  assign exp_in    = bus.in_op[W-2:MAN_W];
  assign frac_in   = bus.in_op[MAN_W-1:0];
  assign exp_zero  = ~|exp_in;
  assign exp_ones  = &exp_in;
  assign frac_zero = ~|frac_in;
  assign frac_msb  = frac_in[MAN_W-1];

  // NaN > inf > zero > sub > normal; in_core only matters for normal operands.
  always_comb begin
    sel_result = core1_reg;
    sel_flags  = 3'b000;
    if (qnan1_reg | snan1_reg) begin
      sel_result = CANON_NAN ? QNAN : (op1_reg | QUIET);
      sel_flags  = {snan1_reg, 1'b0, 1'b1};
    end else if (inf1_reg) begin
      sel_result = QNAN;
      sel_flags  = 3'b101;
    end else if (zero1_reg) begin
      sel_result = func1_reg ? ONE : op1_reg;
      sel_flags  = 3'b001;
    end else if (sub1_reg) begin
      sel_result = func1_reg ? ONE : op1_reg;
      sel_flags  = 3'b011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg         <= 1'b0;
      op1_reg        <= '0;
      core1_reg      <= '0;
      func1_reg      <= 1'b0;
      zero1_reg      <= 1'b0;
      sub1_reg       <= 1'b0;
      inf1_reg       <= 1'b0;
      qnan1_reg      <= 1'b0;
      snan1_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_flags_reg  <= 3'b000;
      sticky_reg     <= 1'b0;
    end else begin
      if (en) begin
        v1_reg         <= bus.in_valid;
        op1_reg        <= bus.in_op;
        core1_reg      <= bus.in_core;
        func1_reg      <= bus.in_func;
        zero1_reg      <= exp_zero & frac_zero;
        sub1_reg       <= exp_zero & !frac_zero;
        inf1_reg       <= exp_ones & frac_zero;
        qnan1_reg      <= exp_ones & frac_msb;
        snan1_reg      <= exp_ones & !frac_zero & !frac_msb;
        out_valid_reg  <= v1_reg;
        out_result_reg <= sel_result;
        out_flags_reg  <= sel_flags;
      end
      // A delivered invalid result beats a simultaneous clear.
      if (out_valid_reg & bus.out_ready & out_flags_reg[2])
        sticky_reg <= 1'b1;
      else if (bus.clr_sticky)
        sticky_reg <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = out_result_reg;
  assign bus.out_flags  = out_flags_reg;
  assign bus.sticky_inv = sticky_reg;
endmodule

// File: tb/tb_fp_trig_special_stage.sv
// Directed checks of the sin/cos special-case stage in single precision
// (propagating and canonical NaN) and half precision.
module tb_fp_trig_special_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_trig_special_stage_if #(.W(32)) ifa ();
  fp_trig_special_stage_if #(.W(32)) ifb ();
  fp_trig_special_stage_if #(.W(16)) ifh ();

  fp_trig_special_stage #(.EXP_W(8), .MAN_W(23), .CANON_NAN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fp_trig_special_stage #(.EXP_W(8), .MAN_W(23), .CANON_NAN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  fp_trig_special_stage #(.EXP_W(5), .MAN_W(10), .CANON_NAN(1'b0)) dut_h (
    .clk(clk), .rst(rst), .bus(ifh)
  );

  // The canonical-NaN instance sees exactly the same traffic as dut_a.
  assign ifb.in_valid   = ifa.in_valid;
  assign ifb.in_op      = ifa.in_op;
  assign ifb.in_core    = ifa.in_core;
  assign ifb.in_func    = ifa.in_func;
  assign ifb.out_ready  = ifa.out_ready;
  assign ifb.clr_sticky = ifa.clr_sticky;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic func, input logic [31:0] op,
                       input logic [31:0] core, input logic [31:0] exp_a,
                       input logic [31:0] exp_b, input logic [2:0] exp_f);
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_func  = func;
    ifa.in_op    = op;
    ifa.in_core  = core;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " valid"}, 64'(ifa.out_valid), 64'd1);
    check({tag, " res"}, 64'(ifa.out_result), 64'(exp_a));
    check({tag, " flags"}, 64'(ifa.out_flags), 64'(exp_f));
    check({tag, " res_canon"}, 64'(ifb.out_result), 64'(exp_b));
    $display("txn %s op=%h func=%0d res=%h flags=%b", tag, op, func, ifa.out_result, ifa.out_flags);
  endtask

  task automatic run_h(input string tag, input logic func, input logic [15:0] op,
                       input logic [15:0] exp_r, input logic [2:0] exp_f);
    @(negedge clk);
    ifh.in_valid = 1'b1;
    ifh.in_func  = func;
    ifh.in_op    = op;
    ifh.in_core  = 16'h1234;
    @(posedge clk);
    #1 ifh.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " valid"}, 64'(ifh.out_valid), 64'd1);
    check({tag, " res"}, 64'(ifh.out_result), 64'(exp_r));
    check({tag, " flags"}, 64'(ifh.out_flags), 64'(exp_f));
    $display("txn %s op=%h func=%0d res=%h flags=%b", tag, op, func, ifh.out_result, ifh.out_flags);
  endtask

  logic        s_func [8];
  logic [31:0] s_op   [8];
  logic [31:0] s_core [8];
  logic [31:0] s_exp  [8];

  initial begin
    int          sent, rcvd, cyc;
    logic        prev_stall;
    logic [31:0] prev_res;

    s_func[0] = 1'b0; s_op[0] = 32'h3F000000; s_core[0] = 32'h3EF57744; s_exp[0] = 32'h3EF57744;
    s_func[1] = 1'b1; s_op[1] = 32'h3F800000; s_core[1] = 32'h3F0A5140; s_exp[1] = 32'h3F0A5140;
    s_func[2] = 1'b0; s_op[2] = 32'h00000000; s_core[2] = 32'h11111111; s_exp[2] = 32'h00000000;
    s_func[3] = 1'b1; s_op[3] = 32'h00000000; s_core[3] = 32'h22222222; s_exp[3] = 32'h3F800000;
    s_func[4] = 1'b0; s_op[4] = 32'h40490FDB; s_core[4] = 32'h33333333; s_exp[4] = 32'h33333333;
    s_func[5] = 1'b1; s_op[5] = 32'hFF800000; s_core[5] = 32'h44444444; s_exp[5] = 32'h7FC00000;
    s_func[6] = 1'b0; s_op[6] = 32'h00400000; s_core[6] = 32'h55555555; s_exp[6] = 32'h00400000;
    s_func[7] = 1'b0; s_op[7] = 32'h7FC00000; s_core[7] = 32'h66666666; s_exp[7] = 32'h7FC00000;

    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_op = '0; ifa.in_core = '0; ifa.in_func = 1'b0;
    ifa.out_ready = 1'b0; ifa.clr_sticky = 1'b0;
    ifh.in_valid = 1'b0; ifh.in_op = '0; ifh.in_core = '0; ifh.in_func = 1'b0;
    ifh.out_ready = 1'b1; ifh.clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst valid", 64'(ifa.out_valid), 64'd0);
    check("rst res", 64'(ifa.out_result), 64'd0);
    check("rst flags", 64'(ifa.out_flags), 64'd0);
    check("rst sticky", 64'(ifa.sticky_inv), 64'd0);
    check("rst h valid", 64'(ifh.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("rst in_ready", 64'(ifa.in_ready), 64'd1);
    ifa.out_ready = 1'b1;

    run_a("normal sin", 1'b0, 32'h3F000000, 32'h3EF57744, 32'h3EF57744, 32'h3EF57744, 3'b000);
    run_a("normal cos", 1'b1, 32'h3F000000, 32'h3F60A940, 32'h3F60A940, 32'h3F60A940, 3'b000);
    run_a("sin -0", 1'b0, 32'h80000000, 32'h12345678, 32'h80000000, 32'h80000000, 3'b001);
    run_a("cos -0", 1'b1, 32'h80000000, 32'h12345678, 32'h3F800000, 32'h3F800000, 3'b001);
    @(posedge clk); #1;
    check("sticky after zero", 64'(ifa.sticky_inv), 64'd0);
    run_a("sin sub", 1'b0, 32'h80000005, 32'h12345678, 32'h80000005, 32'h80000005, 3'b011);
    run_a("cos sub", 1'b1, 32'h00000001, 32'h12345678, 32'h3F800000, 32'h3F800000, 3'b011);
    run_a("sin -inf", 1'b0, 32'hFF800000, 32'h12345678, 32'h7FC00000, 32'h7FC00000, 3'b101);
    @(posedge clk); #1;
    check("sticky set", 64'(ifa.sticky_inv), 64'd1);

    // Clear held across a further invalid handshake: the set must win there.
    @(negedge clk);
    ifa.clr_sticky = 1'b1;
    run_a("cos +inf", 1'b1, 32'h7F800000, 32'h12345678, 32'h7FC00000, 32'h7FC00000, 3'b101);
    @(posedge clk); #1;
    check("sticky set beats clr", 64'(ifa.sticky_inv), 64'd1);
    @(posedge clk); #1;
    check("sticky cleared", 64'(ifa.sticky_inv), 64'd0);
    ifa.clr_sticky = 1'b0;

    run_a("snan", 1'b0, 32'h7F800001, 32'h12345678, 32'h7FC00001, 32'h7FC00000, 3'b101);
    run_a("qnan", 1'b1, 32'hFFC00123, 32'h12345678, 32'hFFC00123, 32'h7FC00000, 3'b001);

    run_h("h cos sub", 1'b1, 16'h0001, 16'h3C00, 3'b011);
    run_h("h sin inf", 1'b0, 16'h7C00, 16'h7E00, 3'b101);
    run_h("h cos -0", 1'b1, 16'h8000, 16'h3C00, 3'b001);
    run_h("h snan", 1'b0, 16'h7C01, 16'h7E01, 3'b101);

    // Streaming with random back-pressure.
    sent = 0; rcvd = 0; cyc = 0;
    prev_stall = 1'b0; prev_res = '0;
    while (rcvd < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) check("stall stable", 64'(ifa.out_result), 64'(prev_res));
      ifa.out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        ifa.in_valid = 1'b1;
        ifa.in_func  = s_func[sent];
        ifa.in_op    = s_op[sent];
        ifa.in_core  = s_core[sent];
      end else begin
        ifa.in_valid = 1'b0;
      end
      #1;
      if (ifa.in_valid && ifa.in_ready) sent++;
      if (ifa.out_valid && ifa.out_ready) begin
        check($sformatf("stream %0d", rcvd), 64'(ifa.out_result), 64'(s_exp[rcvd]));
        $display("txn stream %0d res=%h", rcvd, ifa.out_result);
        rcvd++;
      end
      prev_stall = ifa.out_valid && !ifa.out_ready;
      prev_res   = ifa.out_result;
    end
    check("stream count", 64'(rcvd), 64'd8);
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stream no dup", 64'(ifa.out_valid), 64'd0);

    // Fill the pipeline under back-pressure, then reset mid-stream.
    @(negedge clk);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_func   = 1'b0;
    ifa.in_op     = 32'h3F000000;
    ifa.in_core   = 32'hAAAA5555;
    @(negedge clk);
    ifa.in_core   = 32'h5555AAAA;
    @(negedge clk);
    ifa.in_valid  = 1'b0;
    check("pre-rst valid", 64'(ifa.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid rst valid", 64'(ifa.out_valid), 64'd0);
    check("mid rst res", 64'(ifa.out_result), 64'd0);
    check("mid rst flags", 64'(ifa.out_flags), 64'd0);
    check("mid rst in_ready", 64'(ifa.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("dropped %0d", k), 64'(ifa.out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
